phase_timer: RTL and testbench

//  Shared phase-duration timer answering the traffic-light controller's enable/done handshake.

---
 rtl/phase_timer.sv | 140 ++++++++++++++
 tb/tb_phase_timer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/phase_timer.sv
// Shared programmable phase timer for the traffic-light controller: one C1/C2/C3 enable in, matching W1/W2/W3 done pulse out.
// Optional freeze input 'hold' is compiled in when PHASE_TIMER_HOLD_EN is defined.
module phase_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int T_G1     = 40,
  parameter int T_G2     = 45,
  parameter int T_Y      = 5
) (
  input  logic       clk,
  input  logic       reset,
`ifdef PHASE_TIMER_HOLD_EN
  input  logic       hold,
`endif
  input  logic       C1,
  input  logic       C2,
  input  logic       C3,
  output logic       W1,
  output logic       W2,
  output logic       W3,
  output logic       busy,
  output logic [6:0] remain,
  output logic [7:0] remain_bcd,
  output logic       err
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [6:0]      count_q, count_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      w_q, w_d;
  logic [7:0]      bcd_q, bcd_d;
  logic            err_q, err_d;
  logic [2:0]      en;
  logic            hold_act;
  logic            tick;

  assign en   = {C3, C2, C1};
  assign tick = (presc_q == PW'(TICK_DIV - 1));

`ifdef PHASE_TIMER_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    sel_d   = sel_q;
    w_d     = '0;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (|en) begin
          state_d = S_RUN;
          presc_d = '0;
          if (en[0]) begin
            sel_d   = 3'b001;
            count_d = 7'(T_G1);
          end else if (en[1]) begin
            sel_d   = 3'b010;
            count_d = 7'(T_G2);
          end else begin
            sel_d   = 3'b100;
            count_d = 7'(T_Y);
          end
          if ($countones(en) > 1) err_d = 1'b1;
        end
      end

      S_RUN: begin
        // Abort wins over a coincident tick: a dropped enable never yields a done pulse.
        if (!(|(en & sel_q))) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (!hold_act) begin
          if (tick) begin
            presc_d = '0;
            count_d = count_q - 7'd1;
            if (count_q == 7'd1) begin
              w_d     = sel_q;
              state_d = S_DONE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end

      S_DONE: begin
        if (!(|en)) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    bcd_d = to_bcd(count_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      count_q <= '0;
      sel_q   <= '0;
      w_q     <= '0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      sel_q   <= sel_d;
      w_q     <= w_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
    end
  end

  assign W1         = w_q[0];
  assign W2         = w_q[1];
  assign W3         = w_q[2];
  assign busy       = (state_q == S_RUN);
  assign remain     = count_q;
  assign remain_bcd = bcd_q;
  assign err        = err_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer with an elapsed-time reference model compared every cycle.
// Define PHASE_TIMER_HOLD_EN for both files to exercise the hold input.
module tb_phase_timer;
  localparam int TICK_DIV = 4;
  localparam int T_G1     = 3;
  localparam int T_G2     = 5;
  localparam int T_Y      = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       C1 = 1'b0, C2 = 1'b0, C3 = 1'b0;
  logic       hold = 1'b0;
  logic       W1, W2, W3, busy, err;
  logic [6:0] remain;
  logic [7:0] remain_bcd;

  int n_checks = 0;
  int n_pass   = 0;

  phase_timer #(.TICK_DIV(TICK_DIV), .T_G1(T_G1), .T_G2(T_G2), .T_Y(T_Y)) dut (
    .clk(clk),
    .reset(reset),
`ifdef PHASE_TIMER_HOLD_EN
    .hold(hold),
`endif
    .C1(C1), .C2(C2), .C3(C3),
    .W1(W1), .W2(W2), .W3(W3),
    .busy(busy),
    .remain(remain),
    .remain_bcd(remain_bcd),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: time in a phase is an elapsed-cycle count; seconds left is derived by division.
  typedef enum {M_IDLE, M_RUN, M_DONE} mmode_e;
  mmode_e     m_mode    = M_IDLE;
  int         m_sel     = 0;
  int         m_t       = 0;
  int         m_elapsed = 0;
  int         m_remain  = 0;
  logic [2:0] m_w       = '0;
  logic       m_err     = 1'b0;
  logic [2:0] m_en;

  function automatic int t_of(input int s);
    return (s == 0) ? T_G1 : (s == 1) ? T_G2 : T_Y;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_mode = M_IDLE; m_remain = 0; m_w = '0; m_err = 1'b0; m_elapsed = 0;
    end else begin
      m_en = {C3, C2, C1};
      m_w  = '0;
      case (m_mode)
        M_IDLE: if (m_en != 0) begin
          m_sel     = m_en[0] ? 0 : (m_en[1] ? 1 : 2);
          m_t       = t_of(m_sel);
          m_elapsed = 0;
          m_remain  = m_t;
          m_mode    = M_RUN;
          if ($countones(m_en) > 1) m_err = 1'b1;
        end
        M_RUN: if (!m_en[m_sel]) begin
          m_mode   = M_IDLE;
          m_remain = 0;
        end else if (!hold) begin
          m_elapsed++;
          m_remain = m_t - m_elapsed / TICK_DIV;
          if (m_elapsed == m_t * TICK_DIV) begin
            m_w[m_sel] = 1'b1;
            m_mode     = M_DONE;
          end
        end
        default: if (m_en == 0) m_mode = M_IDLE;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    check("cmp_w",      {29'd0, W3, W2, W1}, {29'd0, m_w});
    check("cmp_busy",   {31'd0, busy}, {31'd0, m_mode == M_RUN});
    check("cmp_remain", {25'd0, remain}, 32'(m_remain));
    check("cmp_bcd",    {24'd0, remain_bcd}, 32'((m_remain / 10) * 16 + m_remain % 10));
    check("cmp_err",    {31'd0, err}, {31'd0, m_err});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called one step after the load edge; measures edges from load to the W pulse.
  task automatic wait_w(input int idx, input int exp, input string name);
    int         cyc;
    logic [2:0] w;
    cyc = 0;
    w   = {W3, W2, W1};
    while (!w[idx] && cyc < 100) begin
      step(1);
      cyc++;
      w = {W3, W2, W1};
    end
    check(name, cyc, exp);
    check({name, "_onehot"}, {29'd0, w}, 32'(1 << idx));
    check({name, "_remain0"}, {25'd0, remain}, 0);
  endtask

  task automatic count_pulses(input int n, output int k);
    k = 0;
    repeat (n) begin
      step(1);
      k += int'(W1) + int'(W2) + int'(W3);
    end
  endtask

  initial begin
    int k;
    int cyc;
    logic [6:0] r;

    #2;
    check("rst_outs", {12'd0, W3, W2, W1, busy, remain, remain_bcd, err}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1);

    // 1: phase 1, W1 after 12 cycles, no retrigger while C1 held
    C1 = 1'b1; step(1);
    check("t1_remain_load", {25'd0, remain}, 3);
    check("t1_busy", {31'd0, busy}, 1);
    wait_w(0, 12, "t1_w1_latency");
    count_pulses(10, k);
    check("t1_no_retrigger", k, 0);

    // 2: phase 2 then yellow
    C1 = 1'b0; step(2);
    C2 = 1'b1; step(1);
    check("t2_bcd_load", {24'd0, remain_bcd}, 32'h05);
    wait_w(1, 20, "t2_w2_latency");
    C2 = 1'b0; step(2);
    C3 = 1'b1; step(1);
    wait_w(2, 8, "t2_w3_latency");

    // 3: yellow aborted 5 cycles after load, then full restart
    C3 = 1'b0; step(2);
    C3 = 1'b1; step(1);
    step(5);
    C3 = 1'b0; step(1);
    check("t3_abort_busy", {31'd0, busy}, 0);
    check("t3_abort_remain", {25'd0, remain}, 0);
    count_pulses(12, k);
    check("t3_no_w3", k, 0);
    C3 = 1'b1; step(1);
    check("t3_reload", {25'd0, remain}, 2);
    wait_w(2, 8, "t3_w3_latency");

    // 4: C1 and C2 together -> phase 1 wins, err sticky
    C3 = 1'b0; step(2);
    C1 = 1'b1; C2 = 1'b1; step(1);
    check("t4_err_set", {31'd0, err}, 1);
    wait_w(0, 12, "t4_w1_latency");
    C1 = 1'b0; C2 = 1'b0; step(4);
    check("t4_err_sticky", {31'd0, err}, 1);

    // 5: asynchronous reset mid-run of phase 2
    C2 = 1'b1; step(1);
    step(8);
    #3 reset = 1'b1;
    #1 check("t5_async_rst", {12'd0, W3, W2, W1, busy, remain, remain_bcd, err}, 0);
    C2 = 1'b0;
    #3 reset = 1'b0;
    step(1);
    count_pulses(25, k);
    check("t5_no_w2", k, 0);
    C2 = 1'b1; step(1);
    wait_w(1, 20, "t5_w2_latency");

`ifdef PHASE_TIMER_HOLD_EN
    // 6: hold for 7 cycles mid-run extends phase 1 to 19 cycles
    C2 = 1'b0; step(2);
    C1 = 1'b1; step(1);
    step(5);
    cyc = 5;
    r = remain;
    hold = 1'b1;
    repeat (7) begin
      step(1);
      cyc++;
      check("t6_hold_remain", {25'd0, remain}, {25'd0, r});
    end
    hold = 1'b0;
    while (!W1 && cyc < 100) begin
      step(1);
      cyc++;
    end
    check("t6_w1_latency", cyc, 19);
    C1 = 1'b0;
`else
    C2 = 1'b0;
`endif

    step(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
